// File: rtl/fp_dot_pipe_hs_if.sv
// Handshake bundle between the operand fetch unit, the FP32 dot-product
// pipeline and the result writeback FIFO.
interface fp_dot_pipe_hs_if #(
    parameter int N     = 4,
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [N*32-1:0]   in_x;
    logic [N*32-1:0]   in_y;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_z;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_flags;
    logic              busy;

    modport master (
        output in_valid, in_x, in_y, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag, out_flags, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag, out_flags, busy
    );
endinterface

// File: rtl/fp_dot_pipe_hs.sv
// N-lane FP32 dot product z = sum x[i]*y[i]: four elastic stages
// (multiply, align/add, normalize, round/pack) with special-value handling.
module fp_dot_pipe_hs #(
    parameter int N     = 4,
    parameter int GUARD = 8,
    parameter int TAG_W = 4
) (
    input logic             gclk,
    input logic             rst,
    fp_dot_pipe_hs_if.slave bus
);
    localparam int F  = 48 + GUARD;
    localparam int LG = $clog2(N);
    localparam int SW = F + LG + 1;
    localparam int PW = $clog2(SW);
    localparam int HB = 46 + GUARD;   // field bit holding the 1.0 weight of a product

    function automatic logic [35:0] round_pack(input logic sgn, input logic [23:0] m,
                                               input logic g, input logic r, input logic s,
                                               input logic signed [11:0] e);
        logic               up;
        logic [24:0]        m25;
        logic signed [11:0] e2;
        logic [22:0]        frac;
        up   = g && (r || s || m[0]);
        m25  = {1'b0, m} + 25'(up);
        e2   = m25[24] ? e + 12'sd1 : e;
        frac = m25[24] ? m25[23:1] : m25[22:0];
        if (e2 >= 12'sd255)
            round_pack = {4'b0101, sgn, 8'hFF, 23'd0};
        else if (e2 <= 12'sd0)
            round_pack = {4'b0011, sgn, 31'd0};
        else
            round_pack = {3'b000, g || r || s, sgn, e2[7:0], frac};
    endfunction

    logic v_p1, v_p2, v_p3, v_p4, rdy_en;
    logic adv1, adv2, adv3, adv4;

    assign adv4 = !v_p4 || bus.out_ready;
    assign adv3 = !v_p3 || adv4;
    assign adv2 = !v_p2 || adv3;
    assign adv1 = !v_p1 || adv2;
    assign bus.in_ready = adv1 && rdy_en;
    assign bus.busy     = v_p1 || v_p2 || v_p3 || v_p4;

    // ---- stage 1: unpack, classify, multiply ----
    logic [N-1:0]      l_sign, l_zero, l_nan, l_inv, l_inf;
    logic signed [9:0] l_exp  [N];
    logic [47:0]       l_mant [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0]  xe, ye;
        logic [22:0] xf, yf;
        logic        xz, yz, xi, yi, xn, yn;
        assign xe = bus.in_x[32*i+23 +: 8];
        assign ye = bus.in_y[32*i+23 +: 8];
        assign xf = bus.in_x[32*i +: 23];
        assign yf = bus.in_y[32*i +: 23];
        assign xz = (xe == 8'd0);
        assign yz = (ye == 8'd0);
        assign xi = (xe == 8'hFF) && (xf == 23'd0);
        assign yi = (ye == 8'hFF) && (yf == 23'd0);
        assign xn = (xe == 8'hFF) && (xf != 23'd0);
        assign yn = (ye == 8'hFF) && (yf != 23'd0);
        assign l_nan[i]  = xn || yn;
        assign l_inv[i]  = (xi && yz) || (xz && yi);
        assign l_inf[i]  = (xi || yi) && !xz && !yz && !xn && !yn;
        // special lanes are kept out of the arithmetic path entirely
        assign l_zero[i] = xz || yz || (xe == 8'hFF) || (ye == 8'hFF);
        assign l_sign[i] = bus.in_x[32*i+31] ^ bus.in_y[32*i+31];
        assign l_exp[i]  = $signed({2'b00, xe}) + $signed({2'b00, ye}) - 10'sd127;
        assign l_mant[i] = 48'({1'b1, xf}) * 48'({1'b1, yf});
    end

    logic nv_c, infp_c, infn_c;
    assign infp_c = |(l_inf & ~l_sign);
    assign infn_c = |(l_inf & l_sign);
    assign nv_c   = (|l_nan) || (|l_inv) || (infp_c && infn_c);

    logic [N-1:0]      sign_p1, zero_p1;
    logic signed [9:0] exp_p1  [N];
    logic [47:0]       mant_p1 [N];
    logic              nv_p1, infp_p1, infn_p1;
    logic [TAG_W-1:0]  tag_p1;

    always_ff @(posedge gclk) begin
        if (adv1) begin
            sign_p1 <= l_sign;
            zero_p1 <= l_zero;
            for (int i = 0; i < N; i++) begin
                exp_p1[i]  <= l_exp[i];
                mant_p1[i] <= l_mant[i];
            end
            nv_p1   <= nv_c;
            infp_p1 <= infp_c;
            infn_p1 <= infn_c;
            tag_p1  <= bus.in_tag;
        end
    end

    // ---- stage 2: align to the largest exponent, signed sum ----
    logic signed [9:0]    emax;
    logic signed [10:0]   diff;
    logic [10:0]          sh;
    logic [2*F-1:0]       wide;
    logic [F-1:0]         fld;
    logic signed [SW-1:0] acc;
    logic [SW-1:0]        mag_c;

    always_comb begin
        emax = {1'b1, 9'd0};
        diff = '0;
        sh   = '0;
        wide = '0;
        fld  = '0;
        acc  = '0;
        for (int i = 0; i < N; i++)
            if (!zero_p1[i] && exp_p1[i] > emax) emax = exp_p1[i];
        for (int i = 0; i < N; i++) begin
            if (!zero_p1[i]) begin
                diff = {emax[9], emax} - {exp_p1[i][9], exp_p1[i]};
                sh   = (diff >= 11'(F)) ? 11'(F) : diff;
                wide = {mant_p1[i], {GUARD{1'b0}}, {F{1'b0}}} >> sh;
                fld  = wide[2*F-1:F] | {{(F-1){1'b0}}, |wide[F-1:0]};
                if (sign_p1[i]) acc = acc - $signed(SW'(fld));
                else            acc = acc + $signed(SW'(fld));
            end
        end
        mag_c = acc[SW-1] ? -acc : acc;
    end

    logic [SW-1:0]     mag_p2;
    logic              sgn_p2, allz_p2, zsign_p2, nv_p2, infp_p2, infn_p2;
    logic signed [9:0] emax_p2;
    logic [TAG_W-1:0]  tag_p2;

    always_ff @(posedge gclk) begin
        if (adv2) begin
            mag_p2   <= mag_c;
            sgn_p2   <= acc[SW-1];
            emax_p2  <= emax;
            allz_p2  <= &zero_p1;
            zsign_p2 <= &sign_p1;
            nv_p2    <= nv_p1;
            infp_p2  <= infp_p1;
            infn_p2  <= infn_p1;
            tag_p2   <= tag_p1;
        end
    end

    // ---- stage 3: leading-one detect and normalize ----
    logic [PW-1:0]      lead;
    logic [SW-1:0]      norm;
    logic signed [11:0] exp_c;

    always_comb begin
        lead = '0;
        for (int i = 0; i < SW; i++)
            if (mag_p2[i]) lead = PW'(i);
        norm  = mag_p2 << (PW'(SW - 1) - lead);
        exp_c = {{2{emax_p2[9]}}, emax_p2} + 12'(lead) - 12'(HB);
    end

    logic [23:0]        mant_p3;
    logic               g_p3, r_p3, s_p3, sgn_p3, zero_p3, zs_p3, nv_p3, infp_p3, infn_p3;
    logic signed [11:0] exp_p3;
    logic [TAG_W-1:0]   tag_p3;

    always_ff @(posedge gclk) begin
        if (adv3) begin
            mant_p3 <= norm[SW-1 -: 24];
            g_p3    <= norm[SW-25];
            r_p3    <= norm[SW-26];
            s_p3    <= |norm[SW-27:0];
            exp_p3  <= exp_c;
            sgn_p3  <= sgn_p2;
            zero_p3 <= (mag_p2 == '0);
            zs_p3   <= allz_p2 && zsign_p2;
            nv_p3   <= nv_p2;
            infp_p3 <= infp_p2;
            infn_p3 <= infn_p2;
            tag_p3  <= tag_p2;
        end
    end

    // ---- stage 4: round, pack, special-value override ----
    logic [31:0] z_c;
    logic [3:0]  f_c;

    always_comb begin
        {f_c, z_c} = round_pack(sgn_p3, mant_p3, g_p3, r_p3, s_p3, exp_p3);
        if (nv_p3) begin
            z_c = 32'h7FC00000;
            f_c = 4'b1000;
        end else if (infp_p3 || infn_p3) begin
            z_c = {infn_p3, 8'hFF, 23'd0};
            f_c = 4'b0000;
        end else if (zero_p3) begin
            z_c = {zs_p3, 31'd0};
            f_c = 4'b0000;
        end
    end

    logic [31:0]      z_p4;
    logic [3:0]       f_p4;
    logic [TAG_W-1:0] tag_p4;

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            rdy_en <= 1'b0;
            v_p1   <= 1'b0;
            v_p2   <= 1'b0;
            v_p3   <= 1'b0;
            v_p4   <= 1'b0;
            z_p4   <= '0;
            f_p4   <= '0;
            tag_p4 <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (adv1) v_p1 <= bus.in_valid && bus.in_ready;
            if (adv2) v_p2 <= v_p1;
            if (adv3) v_p3 <= v_p2;
            if (adv4) v_p4 <= v_p3;
            if (adv4 && v_p3) begin
                z_p4   <= z_c;
                f_p4   <= f_c;
                tag_p4 <= tag_p3;
            end
        end
    end

    assign bus.out_valid = v_p4;
    assign bus.out_z     = z_p4;
    assign bus.out_flags = f_p4;
    assign bus.out_tag   = tag_p4;
endmodule

// File: doc/fp_dot_pipe_hs.md
Name: fp_dot_pipe_hs

Overview:
- Parametrised N-lane FP32 dot-product engine: z = sum over i of x[i]*y[i], using IEEE-754 binary32 formats.
- It is a 4-stage pipeline: multiply, align/add, normalize, round/pack.
- Each stage has its own valid/ready backpressure and bubble collapse, plus special-value handling and exception flags.
- It sits between the operand fetch unit and the result writeback FIFO of the ALU cluster.

Parameters:
- N, 4, number of product lanes; must be a power of 2, range 2..16.
- GUARD, 8, extra alignment bits kept below the product LSB before sticky collapse.
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- gclk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept an operand vector this cycle.
- in_x  in  N*32  lane i is bits [32i+31:32i].
- in_y  in  N*32  same lane packing as in_x.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_z  out  32  FP32 result.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  4  {NV, OF, UF, NX}.
- busy  out  1  any stage holds a valid operation.

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low on rst; clock is gclk.
  - While rst=0, all stage valids clear; out_valid=0, out_z=0, out_tag=0, out_flags=0, busy=0.
  - in_ready=1 one cycle after rst deasserts.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Handshake:
  - An input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
  - Stage k advances when v[k]=0 or stage k+1 advances. Stage 4 advances when out_valid=0 or out_ready=1.
  - in_ready equals the stage-1 advance condition.
  - Held stages keep all their registers stable.
  - Capacity is 4 operations; bubbles collapse.
  - out_z, out_tag and out_flags are stable while out_valid=1 and out_ready=0.
- Latency:
  - 4 cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 operation per cycle.
  - Results leave in acceptance order.
- S1 (unpack/multiply):
  - Denormal inputs are treated as signed zero (FTZ).
  - Per lane: sign = xs ^ ys; exponent sum = xe + ye - 127, held in a 10-bit signed value.
  - 24x24 mantissa product gives an exact 48-bit result.
  - Special-class detection: NaN, Inf, zero.
- S2 (align/add):
  - emax is the maximum exponent over the non-zero products.
  - Each product is shifted right by (emax - ei) into a 48+GUARD-bit field; all bits shifted out are ORed into the field LSB (sticky).
  - A shift of 48+GUARD or more leaves only the sticky bit.
  - Fields are sign-applied and summed in two's complement, with width 48+GUARD+log2(N)+1.
  - Result sign is taken from the sum; the magnitude is the absolute value.
- S3 (normalize):
  - Leading-one detect, then left or right shift so the MSB is the hidden bit.
  - Exponent adjusts by the shift amount.
  - Bits below the round position collapse to guard, round and sticky.
- S4 (round/pack):
  - Round-to-nearest-even.
  - A mantissa carry-out increments the exponent.
  - Biased exponent of 255 or more gives signed Inf with OF=1 and NX=1.
  - Biased exponent of 0 or less gives signed zero with UF=1 and NX=1.
  - NX=1 whenever any discarded bit was non-zero.
- Special cases (take priority over the arithmetic path):
  - Any NaN input, Inf*0, or +Inf and -Inf products together: out_z=0x7FC00000 and NV=1.
  - Inf products of one sign only: signed Inf, flags=0.
  - Exact cancellation: out_z=0x00000000.
  - All products zero: sign = AND of the product signs.
- Flags are sticky per operation only; they do not accumulate across results.
- busy is the OR of the four stage valids.

Test Plan:
- N=4, x={0x3F800000,0x40000000,0x40400000,0x40800000}, y all 0x3F800000 -> after 4 cycles out_z=0x41200000 (10.0), flags=0.
- x={0x3F800000,0xBF800000,0,0}, y all 1.0 -> out_z=0x00000000, flags=0. All products -0 -> out_z=0x80000000.
- Special values:
  - Lane0 x=0x7F800000, y=0 -> out_z=0x7FC00000, NV=1.
  - Lane0 x=0x7F7FFFFF, y=0x40000000, other lanes 0 -> out_z=0x7F800000, flags=0101 (OF, NX).
- Rounding: x0=0x3F800000, y0=1.0, x1=0x33800000 (2^-24), y1=1.0 -> out_z=0x3F800000 (tie rounds to even), NX=1; with x1=0x33800001 -> out_z=0x3F800001.
- Backpressure: 8 back-to-back operations with tags 0..7; out_ready=0 from cycle 3 to 10.
  - in_ready drops after 4 operations are held; outputs remain stable.
  - On release, tags 0..7 emerge in order with correct results; there is no loss or duplication.
- Reset: rst pulsed low with 3 operations in flight -> out_valid=0 immediately (asynchronously), busy=0, none of the old tags appear afterwards; a fresh operation completes in 4 cycles.
